fp_div_iter: RTL
================

# fp_div_iter

Iterative single-precision (IEEE-754 binary32) divider for the FP execute path of the RV32IF core. It takes operands from the FP decode stage (`rs1_data_f_out` / `rs2_data_f_out`) for FDIV.S. It computes the quotient with a radix-2 restoring loop and hands a rounded result, destination tag and exception flags to the FP memory stage. While it is busy it drives `flag_done` low, which is the stall input the ID stage and FP decoder already expose.

## Interface
- No parameters. The format is fixed at binary32 and rounding is fixed at round-to-nearest-even (RNE).
- `clk`  in  1  Core clock. Single clock domain.
- `rst`  in  1  Reset. Synchronous, active-high.
- `start`  in  1  Request a divide. Sampled only in IDLE.
- `flush`  in  1  Abort any in-flight operation (pipeline flush).
- `a_f`  in  32  Dividend.
- `b_f`  in  32  Divisor.
- `rd_in`  in  5  Destination FP register tag.
- `wb_enable_in`  in  1  Write-back enable for this instruction.
- `result_f`  out  32  Quotient.
- `fflags`  out  5  Exception flags {NV, DZ, OF, UF, NX}.
- `rd_out`  out  5  Latched `rd_in`.
- `wb_enable_out`  out  1  Latched `wb_enable_in`, qualified by `result_valid`.
- `result_valid`  out  1  One-cycle pulse: outputs are valid this cycle.
- `flag_done`  out  1  High when no divide is in flight. Low from the cycle after `start` is accepted until `result_valid`.

## Operation
- **States:** IDLE, DIVIDE, ROUND, DONE.
- **Accepting a request:** `start` is accepted in IDLE when `flush` is low.
  - `a_f`, `b_f`, `rd_in` and `wb_enable_in` are latched.
  - `start` in any other state is ignored.
- **Input classification (at accept):**
  - Subnormal inputs are treated as signed zero (denormals-are-zero).
  - Result sign = sign(a) XOR sign(b).
- **Special cases:** handled at accept, going straight IDLE→DONE.
  - Any NaN operand, 0/0, or inf/inf gives `0x7FC00000`. NV is set for sNaN, 0/0 and inf/inf.
  - finite/0 (dividend nonzero) gives ±inf with DZ.
  - inf/finite gives ±inf.
  - 0/nonzero and finite/inf give ±0.
- **Normal path:**
  - Mantissas are ma = {1, frac_a} and mb = {1, frac_b}, 24 bits each.
  - DIVIDE runs 26 iterations, one quotient bit per edge, producing q[25:0] where q[25] has weight 2^0.
  - Each iteration: shift the remainder left by 1, compare with mb, subtract if ≥ mb, and shift the result bit into q.
- **Normalisation (ROUND):**
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem≠0).
  - If q[25]=0: mantissa = q[24:1], guard = q[0], sticky = (rem≠0), and the exponent is decremented.
  - Exponent is computed in 10-bit signed arithmetic as ea − eb + 127 (− 1 in the q[25]=0 case).
- **Rounding (RNE):**
  - Increment if guard & (sticky | mantissa[0]).
  - If the mantissa carries out, the exponent is incremented.
  - NX = guard | sticky.
- **Range checks:**
  - Final exponent ≥ 255 gives ±inf with OF and NX.
  - Final exponent ≤ 0 gives ±0 with UF and NX (flush-to-zero, no subnormal output).
- **DONE:** lasts one cycle with `result_valid` = 1, then returns to IDLE.
- **Flush:**
  - `flush` in DIVIDE or ROUND returns to IDLE at the next edge. No `result_valid` is produced and the tag is discarded.
  - `flush` in DONE suppresses `result_valid` and `wb_enable_out` for that cycle.
- **Reset:** `rst` has priority over `flush`, and `flush` has priority over `start`.

## Timing
- **Reset values:** state = IDLE, `result_f` = 0, `fflags` = 0, `rd_out` = 0, `wb_enable_out` = 0, `result_valid` = 0, `flag_done` = 1.
- **Reset mid-operation:** the in-flight divide is discarded and all reset values apply at the next edge.
- **Accept edge:** the edge that samples `start` is edge E0.
- **Normal latency:**
  - Iterations occur at E1..E26.
  - ROUND packs the result at E27.
  - `result_valid` is high in the cycle after E27, i.e. 28 cycles after `start`.
  - `flag_done` is low from after E0 through the cycle before `result_valid`, and high in the DONE cycle.
- **Special-case latency:** `result_valid` is high in the cycle after E0, and `flag_done` stays high.
- **Output hold:** `result_f`, `fflags` and `rd_out` hold their values until the next result. Only `result_valid` and `wb_enable_out` pulse.
- **Back-to-back issue:** a new `start` is accepted at the earliest in the cycle after DONE, once the block is back in IDLE.

## Test plan
- **Normal divide:** `a_f`=`0x40C00000` (6.0), `b_f`=`0x40000000` (2.0) → `result_f`=`0x40400000`, `fflags`=0, `result_valid` 28 cycles after `start`, `rd_out`=`rd_in`.
- **Inexact:** 1.0/3.0 (`0x3F800000`/`0x40400000`) → `0x3EAAAAAB`, `fflags`=NX (`5'b00001`).
- **Specials, latency 1:**
  - `0x3F800000`/`0x00000000` → `0x7F800000`, DZ.
  - `0x00000000`/`0x00000000` → `0x7FC00000`, NV.
  - `0x80000000`/`0x3F800000` → `0x80000000`, no flags.
- **Range:**
  - `0x7F7FFFFF`/`0x3E800000` → `0x7F800000`, OF|NX.
  - `0x00800000`/`0x40800000` → `0x00000000`, UF|NX.
- **Control:**
  - `start` pulsed again at E5 → ignored, and the first result is unchanged.
  - `flush` at E10 → no `result_valid`, `flag_done`=1 next cycle, and a new `start` is accepted after.
- **Reset mid-operation:** `rst` at E15 → all outputs at reset values next cycle. A subsequent 6.0/2.0 divide completes correctly.

Source files
------------

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider (radix-2 restoring, RNE, DAZ/FTZ) for FDIV.S.
// Specials resolve at accept; normal operands take 26 quotient steps plus one pack cycle.
module fp_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] a_f,
    input  logic [31:0] b_f,
    input  logic [4:0]  rd_in,
    input  logic        wb_enable_in,
    output logic [31:0] result_f,
    output logic [4:0]  fflags,
    output logic [4:0]  rd_out,
    output logic        wb_enable_out,
    output logic        result_valid,
    output logic        flag_done
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIVIDE = 2'd1, S_ROUND = 2'd2, S_DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [23:0] mb_q, mb_d;
    logic [9:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_q, wb_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  fflags_q, fflags_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        a_nan_s, b_nan_s, a_snan_s, b_snan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s, sign_in_s;
    logic        is_spec_s;
    logic [31:0] spec_res_s;
    logic [4:0]  spec_flags_s;

    assign a_nan_s   = (a_f[30:23] == 8'hFF) && (a_f[22:0] != 23'd0);
    assign b_nan_s   = (b_f[30:23] == 8'hFF) && (b_f[22:0] != 23'd0);
    assign a_snan_s  = a_nan_s && !a_f[22];
    assign b_snan_s  = b_nan_s && !b_f[22];
    assign a_inf_s   = (a_f[30:23] == 8'hFF) && (a_f[22:0] == 23'd0);
    assign b_inf_s   = (b_f[30:23] == 8'hFF) && (b_f[22:0] == 23'd0);
    // Subnormals are read as zero, so a zero exponent alone marks a zero operand.
    assign a_zero_s  = (a_f[30:23] == 8'd0);
    assign b_zero_s  = (b_f[30:23] == 8'd0);
    assign sign_in_s = a_f[31] ^ b_f[31];

    // Special-operand resolution, flags ordered {NV, DZ, OF, UF, NX}
    always_comb begin
        is_spec_s    = 1'b1;
        spec_res_s   = 32'h7FC0_0000;
        spec_flags_s = 5'b00000;
        if (a_nan_s || b_nan_s) begin
            spec_flags_s = (a_snan_s || b_snan_s) ? 5'b10000 : 5'b00000;
        end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_flags_s = 5'b10000;
        end else if (a_inf_s) begin
            spec_res_s = {sign_in_s, 8'hFF, 23'd0};
        end else if (b_zero_s) begin
            spec_res_s   = {sign_in_s, 8'hFF, 23'd0};
            spec_flags_s = 5'b01000;
        end else if (a_zero_s || b_inf_s) begin
            spec_res_s = {sign_in_s, 31'd0};
        end else begin
            is_spec_s = 1'b0;
        end
    end

    logic        ge_s;
    logic [24:0] rem_sub_s;
    logic        norm_hi_s, guard_s, sticky_s, rnd_up_s, inexact_s, ovf_s, unf_s;
    logic [23:0] mant_s;
    logic [24:0] mant_r_s;
    logic [9:0]  exp_n_s, exp_f_s;
    logic [22:0] frac_f_s;

    assign ge_s      = rem_q >= {1'b0, mb_q};
    assign rem_sub_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;

    assign norm_hi_s = quo_q[25];
    assign mant_s    = norm_hi_s ? quo_q[25:2] : quo_q[24:1];
    assign guard_s   = norm_hi_s ? quo_q[1] : quo_q[0];
    assign sticky_s  = (norm_hi_s && quo_q[0]) || (rem_q != 25'd0);
    assign exp_n_s   = norm_hi_s ? exp_q : (exp_q - 10'd1);
    assign rnd_up_s  = guard_s && (sticky_s || mant_s[0]);
    assign mant_r_s  = {1'b0, mant_s} + {24'd0, rnd_up_s};
    assign exp_f_s   = mant_r_s[24] ? (exp_n_s + 10'd1) : exp_n_s;
    assign frac_f_s  = mant_r_s[24] ? mant_r_s[23:1] : mant_r_s[22:0];
    assign inexact_s = guard_s || sticky_s;
    assign ovf_s     = $signed(exp_f_s) >= $signed(10'd255);
    assign unf_s     = $signed(exp_f_s) <= $signed(10'd0);

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mb_d     = mb_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        rd_d     = rd_q;
        wb_d     = wb_q;
        result_d = result_q;
        fflags_d = fflags_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    rd_d   = rd_in;
                    wb_d   = wb_enable_in;
                    sign_d = sign_in_s;
                    if (is_spec_s) begin
                        result_d = spec_res_s;
                        fflags_d = spec_flags_s;
                        rd_out_d = rd_in;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = {1'b0, 1'b1, a_f[22:0]};
                        mb_d    = {1'b1, b_f[22:0]};
                        exp_d   = {2'b00, a_f[30:23]} - {2'b00, b_f[30:23]} + 10'd127;
                        quo_d   = 26'd0;
                        cnt_d   = 5'd0;
                        state_d = S_DIVIDE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIVIDE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_sub_s << 1;
                    quo_d = {quo_q[24:0], ge_s};
                    cnt_d = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd25) ? S_ROUND : S_DIVIDE;
                end
            end
            S_ROUND: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                    if (ovf_s) begin
                        result_d = {sign_q, 8'hFF, 23'd0};
                        fflags_d = 5'b00101;
                    end else if (unf_s) begin
                        result_d = {sign_q, 31'd0};
                        fflags_d = 5'b00011;
                    end else begin
                        result_d = {sign_q, exp_f_s[7:0], frac_f_s};
                        fflags_d = {4'b0000, inexact_s};
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 25'd0;
            quo_q    <= 26'd0;
            mb_q     <= 24'd0;
            exp_q    <= 10'd0;
            sign_q   <= 1'b0;
            rd_q     <= 5'd0;
            wb_q     <= 1'b0;
            result_q <= 32'd0;
            fflags_q <= 5'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mb_q     <= mb_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            result_q <= result_d;
            fflags_q <= fflags_d;
            rd_out_q <= rd_out_d;
        end
    end

    // A flush landing in DONE must kill the pulse in that same cycle.
    assign result_valid  = (state_q == S_DONE) && !flush;
    assign wb_enable_out = wb_q && result_valid;
    assign flag_done     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign result_f      = result_q;
    assign fflags        = fflags_q;
    assign rd_out        = rd_out_q;
endmodule
